nx_node_exec: RTL and testbench

NX_NODE_EXEC -- requirements
Module: nx_node_exec

---
 rtl/nx_node_exec.sv | 156 +++++++++++++++
 tb/tb_nx_node_exec.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nx_node_exec.sv
`default_nettype none
// ============================================================================
// nx_node_exec : single-bit logic node, programmable instruction sequencer
//                evaluating a gate program over latched inputs per run pass.
// Revision     : 1.0 - initial release
// ============================================================================
module nx_node_exec #(
  parameter int INSTR_DEPTH = 32,
  parameter int NUM_REGS    = 8,
  parameter int NUM_INS     = 8,
  parameter int NUM_OUTS    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [5:0]          cfg_addr,
  input  logic [15:0]         cfg_data,
  input  logic                run,
  input  logic [NUM_INS-1:0]  inputs,
  output logic [NUM_OUTS-1:0] outputs,
  output logic                busy,
  output logic                done
);

  localparam logic [5:0] ADDR_NUM   = 6'd32;
  localparam logic [5:0] ADDR_MAP0  = 6'd33;
  localparam logic [5:0] ADDR_MAPN  = 6'd40;
  localparam logic [5:0] NUM_MAX    = 6'd32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [4:0]                     pc_q, pc_d;
  logic [NUM_REGS-1:0]            regs_q, regs_d;
  logic [NUM_INS-1:0]             inputs_lat_q, inputs_lat_d;
  logic [NUM_OUTS-1:0]            outputs_q, outputs_d;
  logic                           done_q, done_d;
  logic [5:0]                     num_instr_q, num_instr_d;
  logic [NUM_OUTS-1:0]            map_valid_q, map_valid_d;
  logic [NUM_OUTS-1:0][2:0]       map_reg_q, map_reg_d;

  // Bits [1:0] of an instruction word carry no meaning, so only [15:2] are stored.
  logic [13:0]                    instr_mem_q [INSTR_DEPTH];

  logic                           cfg_wr;
  logic [13:0]                    instr;
  logic                           op_a, op_b, alu_res;

  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign outputs   = outputs_q;
  assign cfg_wr    = cfg_valid && (state_q == S_IDLE);
  assign instr     = instr_mem_q[pc_q];

  always_comb begin
    op_a = instr[10] ? inputs_lat_q[instr[9:7]] : regs_q[instr[9:7]];
    op_b = instr[6]  ? inputs_lat_q[instr[5:3]] : regs_q[instr[5:3]];
    case (instr[13:11])
      3'd0:    alu_res = ~op_a;
      3'd1:    alu_res = op_a & op_b;
      3'd2:    alu_res = ~(op_a & op_b);
      3'd3:    alu_res = op_a | op_b;
      3'd4:    alu_res = ~(op_a | op_b);
      3'd5:    alu_res = op_a ^ op_b;
      3'd6:    alu_res = ~(op_a ^ op_b);
      default: alu_res = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    regs_d       = regs_q;
    inputs_lat_d = inputs_lat_q;
    outputs_d    = outputs_q;
    done_d       = 1'b0;
    num_instr_d  = num_instr_q;
    map_valid_d  = map_valid_q;
    map_reg_d    = map_reg_q;

    // Map slot index: addresses 33..40 have low bits 1..7,0, so subtract one mod 8.
    if (cfg_wr) begin
      if (cfg_addr == ADDR_NUM) begin
        num_instr_d = (cfg_data[5:0] > NUM_MAX) ? NUM_MAX : cfg_data[5:0];
      end else if (cfg_addr >= ADDR_MAP0 && cfg_addr <= ADDR_MAPN) begin
        map_valid_d[cfg_addr[2:0] - 3'd1] = cfg_data[3];
        map_reg_d[cfg_addr[2:0] - 3'd1]   = cfg_data[2:0];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (run) begin
          inputs_lat_d = inputs;
          regs_d       = '0;
          pc_d         = 5'd0;
          state_d      = (num_instr_d != 6'd0) ? S_EXEC : S_COMMIT;
        end
      end
      S_EXEC: begin
        regs_d[instr[2:0]] = alu_res;
        pc_d               = pc_q + 5'd1;
        if ({1'b0, pc_q} == num_instr_q - 6'd1) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        for (int i = 0; i < NUM_OUTS; i++) begin
          outputs_d[i] = map_valid_q[i] & regs_q[map_reg_q[i]];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= 5'd0;
      regs_q       <= '0;
      inputs_lat_q <= '0;
      outputs_q    <= '0;
      done_q       <= 1'b0;
      num_instr_q  <= 6'd0;
      map_valid_q  <= '0;
      map_reg_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      regs_q       <= regs_d;
      inputs_lat_q <= inputs_lat_d;
      outputs_q    <= outputs_d;
      done_q       <= done_d;
      num_instr_q  <= num_instr_d;
      map_valid_q  <= map_valid_d;
      map_reg_q    <= map_reg_d;
    end
  end

  // Program store survives reset so a node can be re-run after an abort.
  always_ff @(posedge clk) begin
    if (cfg_wr && !cfg_addr[5]) begin
      instr_mem_q[cfg_addr[4:0]] <= cfg_data[15:2];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nx_node_exec.sv
`default_nettype none
// ============================================================================
// tb_nx_node_exec : randomized and directed bench with a pass-level model.
// Revision        : 1.0 - initial release
// ============================================================================
module tb_nx_node_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [5:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        run = 1'b0;
  logic [7:0]  inputs = '0;
  logic [7:0]  outputs;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  nx_node_exec dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .run(run), .inputs(inputs),
    .outputs(outputs), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // ---------------- pass-level reference model ----------------
  logic [15:0] m_mem [32];
  int          m_num;
  bit          m_mvalid [8];
  int          m_mreg [8];
  bit          m_busy;
  int          m_left;
  logic [7:0]  m_out, m_pend;
  bit          m_done;

  // Truth tables indexed by {a,b}; op 7 yields 0.
  logic [3:0] tt [8] = '{4'b0011, 4'b1000, 4'b0111, 4'b1110,
                         4'b0001, 4'b0110, 4'b1001, 4'b0000};

  function automatic logic [7:0] eval_pass(input logic [7:0] in);
    bit r [8];
    bit a, b;
    logic [15:0] w;
    logic [7:0] res;
    for (int i = 0; i < 8; i++) r[i] = 0;
    for (int p = 0; p < m_num; p++) begin
      w = m_mem[p];
      a = w[12] ? in[w[11:9]] : r[w[11:9]];
      b = w[8]  ? in[w[7:5]]  : r[w[7:5]];
      r[w[4:2]] = tt[w[15:13]][{a, b}];
    end
    for (int i = 0; i < 8; i++) res[i] = m_mvalid[i] ? r[m_mreg[i]] : 1'b0;
    return res;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_left = 0; m_out = '0; m_done = 0; m_num = 0;
      for (int i = 0; i < 8; i++) begin m_mvalid[i] = 0; m_mreg[i] = 0; end
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (cfg_valid) begin
          if (cfg_addr < 32) m_mem[cfg_addr] = cfg_data;
          else if (cfg_addr == 32) m_num = (cfg_data[5:0] > 32) ? 32 : int'(cfg_data[5:0]);
          else if (cfg_addr <= 40) begin
            m_mvalid[cfg_addr - 33] = cfg_data[3];
            m_mreg[cfg_addr - 33]   = int'(cfg_data[2:0]);
          end
        end
        if (run) begin
          m_pend = eval_pass(inputs);
          m_left = m_num + 1;
          m_busy = 1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_out = m_pend; m_done = 1; m_busy = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("outputs", {24'd0, outputs}, {24'd0, m_out});
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("cfg_ready", {31'd0, cfg_ready}, {31'd0, !m_busy});
    end
  end

  // ---------------- drivers ----------------
  task automatic cfg_write(input logic [5:0] a, input logic [15:0] d);
    int t = 0;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    while (!cfg_ready && t < 200) begin @(negedge clk); t++; end
    if (!cfg_ready) begin
      checks++; failures++;
      $display("FAIL cfg_timeout: got cfg_ready=0 expected 1");
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic start_run(input logic [7:0] in);
    @(negedge clk);
    inputs = in; run = 1'b1;
    @(negedge clk);
    run = 1'b0; inputs = 8'($urandom);
  endtask

  task automatic run_with_write(input logic [5:0] a, input logic [15:0] d, input logic [7:0] in);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d; run = 1'b1; inputs = in;
    @(negedge clk);
    cfg_valid = 1'b0; run = 1'b0; inputs = 8'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    if (!done) begin
      checks++; failures++;
      $display("FAIL done_timeout: got done=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
  endtask

  initial begin
    int cyc;
    int t;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk_en = 1;
    @(negedge clk);
    check("reset_outputs", {24'd0, outputs}, 32'h0);

    // AND in0,in1 -> r0
    cfg_write(6'd0, 16'h3120);
    cfg_write(6'd33, 16'h0008);
    cfg_write(6'd32, 16'h0001);
    start_run(8'h03);
    wait_done(cyc);
    check("and_latency", cyc, 2);
    check("and_out", {24'd0, outputs}, 32'h01);

    // XOR then INVERT
    cfg_write(6'd0, 16'hB124);
    cfg_write(6'd1, 16'h0208);
    cfg_write(6'd33, 16'h0009);
    cfg_write(6'd34, 16'h000A);
    cfg_write(6'd32, 16'h0002);
    start_run(8'h01);
    wait_done(cyc);
    check("xor_inv_01", {24'd0, outputs}, 32'h01);
    start_run(8'h03);
    wait_done(cyc);
    check("xor_inv_03", {24'd0, outputs}, 32'h02);

    // empty program
    cfg_write(6'd33, 16'h0008);
    cfg_write(6'd32, 16'h0000);
    start_run(8'hFF);
    wait_done(cyc);
    check("empty_latency", cyc, 1);
    check("empty_out", {24'd0, outputs}, 32'h00);

    // reserved op clears r0; discarded write
    cfg_write(6'd0, 16'h3120);
    cfg_write(6'd1, 16'hE000);
    cfg_write(6'd32, 16'h0002);
    start_run(8'h03);
    wait_done(cyc);
    check("reserved_op", {24'd0, outputs}, 32'h00);
    cfg_write(6'd50, 16'hFFFF);
    start_run(8'h03);
    wait_done(cyc);
    check("discard_write", {24'd0, outputs}, 32'h00);
    check("discard_latency", cyc, 3);

    // 5-instruction program, maps r0..r4 -> out0..4
    cfg_write(6'd0, 16'h3120);
    cfg_write(6'd1, 16'hB124);
    cfg_write(6'd2, 16'h0208);
    cfg_write(6'd3, 16'h604C);
    cfg_write(6'd4, 16'h9E70);
    for (int i = 0; i < 5; i++) cfg_write(6'(33 + i), 16'(8 + i));
    cfg_write(6'd32, 16'h0005);
    start_run(8'h00);
    wait_done(cyc);
    check("prog5_00", {24'd0, outputs}, 32'h0C);

    // stalled write plus ignored run while busy
    start_run(8'h81);
    check("ready_busy", {31'd0, cfg_ready}, 32'h0);
    cfg_valid = 1'b1; cfg_addr = 6'd35; cfg_data = 16'h0000; run = 1'b1; inputs = 8'h00;
    @(negedge clk);
    run = 1'b0;
    t = 0;
    while (!cfg_ready && t < 100) begin @(negedge clk); t++; end
    check("prog5_81", {24'd0, outputs}, 32'h02);
    @(negedge clk);
    cfg_valid = 1'b0;
    start_run(8'h00);
    wait_done(cyc);
    check("stalled_map_write", {24'd0, outputs}, 32'h08);

    // abort mid-pass
    start_run(8'h00);
    @(negedge clk);
    pulse_reset();
    @(negedge clk);
    check("abort_out", {24'd0, outputs}, 32'h00);
    check("abort_busy", {31'd0, busy}, 32'h0);
    start_run(8'hFF);
    wait_done(cyc);
    check("rerun_latency", cyc, 1);
    check("rerun_out", {24'd0, outputs}, 32'h00);

    // randomized programs
    for (int i = 0; i < 32; i++) cfg_write(6'(i), 16'($urandom));
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 4; k++) cfg_write(6'($urandom_range(0, 31)), 16'($urandom));
      for (int k = 0; k < 8; k++) cfg_write(6'(33 + k), 16'($urandom));
      if ($urandom_range(0, 5) == 0) cfg_write(6'($urandom_range(41, 63)), 16'($urandom));
      if ($urandom_range(0, 7) == 0) cfg_write(6'd32, 16'($urandom));
      else cfg_write(6'd32, 16'($urandom_range(0, 12)));
      if ($urandom_range(0, 2) == 0)
        run_with_write(6'($urandom_range(32, 40)), 16'($urandom_range(0, 15)), 8'($urandom));
      else
        start_run(8'($urandom));
      wait_done(cyc);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
